// File: rtl/coz_pkg.sv
// Shared types and defaults for the multi-port register file and its scoreboard.
package coz_pkg;

    localparam int REGISTER_SAYISI  = 32;
    localparam int SOZCUK_GENISLIGI = 32;
    localparam int ADR_W            = $clog2(REGISTER_SAYISI);

    typedef logic [ADR_W-1:0] yazmac_adr_t;

    // Names one architectural register: which bank and which index.
    typedef struct packed {
        logic        fp;
        yazmac_adr_t adr;
    } yazmac_hedef_t;

    // FP registers come out of reset as all ones (a quiet-NaN style pattern).
    localparam logic [SOZCUK_GENISLIGI-1:0] FP_SIFIR_VARSAYILAN = '1;

endpackage

// File: rtl/puan_tablosu.sv
// Busy scoreboard: one bit per register (both banks), with set/clear/flush
// priority and a registered count of how many bits are set.
module puan_tablosu #(
    parameter int BIT_SAY = 64,
    parameter int SAYAC_W = 7
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [BIT_SAY-1:0] set_i,
    input  logic [BIT_SAY-1:0] clr_i,
    input  logic               flush_i,
    output logic [BIT_SAY-1:0] mesgul_o,
    output logic [SAYAC_W-1:0] bekleyen_o
);

    logic [BIT_SAY-1:0] mesgul_q, mesgul_d;
    logic [SAYAC_W-1:0] sayac_q, sayac_d;

    // Next busy vector: flush beats everything, a new producer beats a clear.
    always_comb begin
        mesgul_d = '0;
        if (!flush_i) begin
            mesgul_d = (mesgul_q & ~clr_i) | set_i;
        end
    end

    // Popcount of the next vector so the count moves together with the bits.
    always_comb begin
        sayac_d = '0;
        for (int i = 0; i < BIT_SAY; i++) begin
            sayac_d = sayac_d + SAYAC_W'(mesgul_d[i]);
        end
    end

    // Scoreboard state and count registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mesgul_q <= '0;
            sayac_q  <= '0;
        end else begin
            mesgul_q <= mesgul_d;
            sayac_q  <= sayac_d;
        end
    end

    assign mesgul_o   = mesgul_q;
    assign bekleyen_o = sayac_q;

endmodule

// File: rtl/yazmac_obegi_cok_portlu.sv
// Multi-port integer/FP register file with write-to-read bypass and a
// per-register busy scoreboard. Reads are combinational; writes land on the
// clock edge. Integer register 0 is hardwired to zero and never busy.
module yazmac_obegi_cok_portlu
    import coz_pkg::*;
#(
    parameter int               OKUMA_PORT = 3,
    parameter int               YAZMA_PORT = 2,
    parameter int               YAZMAC_SAY = REGISTER_SAYISI,
    parameter int               VERI_W     = SOZCUK_GENISLIGI,
    parameter int               BYPASS_EN  = 1,
    parameter logic [VERI_W-1:0] FP_SIFIR  = {VERI_W{FP_SIFIR_VARSAYILAN[0]}}
) (
    input  logic                                      clk_i,
    input  logic                                      rstn_i,
    input  logic [OKUMA_PORT*$clog2(YAZMAC_SAY)-1:0]  oku_adr_i,
    input  logic [OKUMA_PORT-1:0]                     oku_fp_i,
    output logic [OKUMA_PORT*VERI_W-1:0]              oku_veri_o,
    output logic [OKUMA_PORT-1:0]                     oku_mesgul_o,
    input  logic [YAZMA_PORT-1:0]                     yaz_en_i,
    input  logic [YAZMA_PORT-1:0]                     yaz_fp_i,
    input  logic [YAZMA_PORT*$clog2(YAZMAC_SAY)-1:0]  yaz_adr_i,
    input  logic [YAZMA_PORT*VERI_W-1:0]              yaz_veri_i,
    input  logic [YAZMA_PORT-1:0]                     yaz_temizle_i,
    input  logic                                      iss_gecerli_i,
    input  logic                                      iss_fp_i,
    input  logic [$clog2(YAZMAC_SAY)-1:0]             iss_adr_i,
    input  logic                                      temizle_i,
    output logic [$clog2(2*YAZMAC_SAY+1)-1:0]         bekleyen_o
);

    localparam int A       = $clog2(YAZMAC_SAY);
    localparam int BIT_SAY = 2 * YAZMAC_SAY;
    localparam int SAYAC_W = $clog2(2 * YAZMAC_SAY + 1);

    logic [VERI_W-1:0]  int_q [YAZMAC_SAY];
    logic [VERI_W-1:0]  int_d [YAZMAC_SAY];
    logic [VERI_W-1:0]  fp_q  [YAZMAC_SAY];
    logic [VERI_W-1:0]  fp_d  [YAZMAC_SAY];

    // Scoreboard index is {bank, address}: int bank low half, FP bank high half.
    logic [BIT_SAY-1:0] set_v;
    logic [BIT_SAY-1:0] clr_v;
    logic [BIT_SAY-1:0] mesgul_v;

    // Next array contents; ports are walked in ascending order so the highest
    // enabled port hitting the same register is the one that sticks.
    always_comb begin
        int_d = int_q;
        fp_d  = fp_q;
        for (int p = 0; p < YAZMA_PORT; p++) begin
            if (yaz_en_i[p]) begin
                if (yaz_fp_i[p]) begin
                    fp_d[yaz_adr_i[p*A +: A]] = yaz_veri_i[p*VERI_W +: VERI_W];
                end else if (yaz_adr_i[p*A +: A] != '0) begin
                    int_d[yaz_adr_i[p*A +: A]] = yaz_veri_i[p*VERI_W +: VERI_W];
                end
            end
        end
    end

    // Register arrays; reset restores int zeros and the FP reset pattern.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < YAZMAC_SAY; i++) begin
                int_q[i] <= '0;
                fp_q[i]  <= FP_SIFIR;
            end
        end else begin
            int_q <= int_d;
            fp_q  <= fp_d;
        end
    end

    // Scoreboard set/clear requests. The clear follows the same
    // highest-port-wins rule as the data, so a later non-clearing write to
    // the same register cancels an earlier port's clear.
    always_comb begin
        set_v = '0;
        clr_v = '0;
        for (int p = 0; p < YAZMA_PORT; p++) begin
            if (yaz_en_i[p] && (yaz_fp_i[p] || (yaz_adr_i[p*A +: A] != '0))) begin
                clr_v[{yaz_fp_i[p], yaz_adr_i[p*A +: A]}] = yaz_temizle_i[p];
            end
        end
        if (iss_gecerli_i && (iss_fp_i || (iss_adr_i != '0))) begin
            set_v[{iss_fp_i, iss_adr_i}] = 1'b1;
        end
    end

    puan_tablosu #(
        .BIT_SAY (BIT_SAY),
        .SAYAC_W (SAYAC_W)
    ) u_puan_tablosu (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .set_i      (set_v),
        .clr_i      (clr_v),
        .flush_i    (temizle_i),
        .mesgul_o   (mesgul_v),
        .bekleyen_o (bekleyen_o)
    );

    // Read mux per port: array lookup, optionally overridden by a same-cycle
    // write, and a busy flag that drops early when the producer is writing
    // back right now (unless a new producer is issuing to it in this cycle).
    always_comb begin
        logic [A-1:0]      ra;
        logic              rf;
        logic [VERI_W-1:0] veri;
        logic              mesgul;
        ra           = '0;
        rf           = 1'b0;
        veri         = '0;
        mesgul       = 1'b0;
        oku_veri_o   = '0;
        oku_mesgul_o = '0;
        for (int r = 0; r < OKUMA_PORT; r++) begin
            ra     = oku_adr_i[r*A +: A];
            rf     = oku_fp_i[r];
            veri   = rf ? fp_q[ra] : int_q[ra];
            mesgul = mesgul_v[{rf, ra}];
            if (BYPASS_EN != 0) begin
                for (int p = 0; p < YAZMA_PORT; p++) begin
                    if (yaz_en_i[p] && (yaz_fp_i[p] == rf) &&
                        (yaz_adr_i[p*A +: A] == ra) && (rf || (ra != '0))) begin
                        veri = yaz_veri_i[p*VERI_W +: VERI_W];
                    end
                end
                if (clr_v[{rf, ra}] && !set_v[{rf, ra}]) begin
                    mesgul = 1'b0;
                end
            end
            oku_veri_o[r*VERI_W +: VERI_W] = veri;
            oku_mesgul_o[r]                = mesgul;
        end
    end

endmodule

// File: tb/tb_yazmac_obegi_cok_portlu.sv
// Directed bench for the multi-port register file. Two instances share the
// same stimulus: one with bypass enabled, one without.
module tb_yazmac_obegi_cok_portlu;

    localparam int A  = 5;
    localparam int W  = 32;
    localparam int RP = 3;
    localparam int WP = 2;

    logic            clk;
    logic            rstn;
    logic [RP*A-1:0] oku_adr;
    logic [RP-1:0]   oku_fp;
    logic [WP-1:0]   yaz_en;
    logic [WP-1:0]   yaz_fp;
    logic [WP*A-1:0] yaz_adr;
    logic [WP*W-1:0] yaz_veri;
    logic [WP-1:0]   yaz_temizle;
    logic            iss_gecerli;
    logic            iss_fp;
    logic [A-1:0]    iss_adr;
    logic            temizle;

    logic [RP*W-1:0] veri_b, veri_n;
    logic [RP-1:0]   mesgul_b, mesgul_n;
    logic [6:0]      bekleyen_b, bekleyen_n;

    int n_chk  = 0;
    int n_pass = 0;

    yazmac_obegi_cok_portlu #(.BYPASS_EN(1)) u_dut (
        .clk_i(clk), .rstn_i(rstn),
        .oku_adr_i(oku_adr), .oku_fp_i(oku_fp),
        .oku_veri_o(veri_b), .oku_mesgul_o(mesgul_b),
        .yaz_en_i(yaz_en), .yaz_fp_i(yaz_fp), .yaz_adr_i(yaz_adr),
        .yaz_veri_i(yaz_veri), .yaz_temizle_i(yaz_temizle),
        .iss_gecerli_i(iss_gecerli), .iss_fp_i(iss_fp), .iss_adr_i(iss_adr),
        .temizle_i(temizle), .bekleyen_o(bekleyen_b)
    );

    yazmac_obegi_cok_portlu #(.BYPASS_EN(0)) u_dut_nb (
        .clk_i(clk), .rstn_i(rstn),
        .oku_adr_i(oku_adr), .oku_fp_i(oku_fp),
        .oku_veri_o(veri_n), .oku_mesgul_o(mesgul_n),
        .yaz_en_i(yaz_en), .yaz_fp_i(yaz_fp), .yaz_adr_i(yaz_adr),
        .yaz_veri_i(yaz_veri), .yaz_temizle_i(yaz_temizle),
        .iss_gecerli_i(iss_gecerli), .iss_fp_i(iss_fp), .iss_adr_i(iss_adr),
        .temizle_i(temizle), .bekleyen_o(bekleyen_n)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    endtask

    task automatic idle();
        yaz_en      = '0;
        yaz_fp      = '0;
        yaz_adr     = '0;
        yaz_veri    = '0;
        yaz_temizle = '0;
        iss_gecerli = 1'b0;
        iss_fp      = 1'b0;
        iss_adr     = '0;
        temizle     = 1'b0;
    endtask

    task automatic rd(input int p, input logic fp, input logic [A-1:0] adr);
        oku_fp[p]         = fp;
        oku_adr[p*A +: A] = adr;
    endtask

    task automatic wr(input int p, input logic fp, input logic [A-1:0] adr,
                      input logic [W-1:0] d, input logic clr);
        yaz_en[p]          = 1'b1;
        yaz_fp[p]          = fp;
        yaz_adr[p*A +: A]  = adr;
        yaz_veri[p*W +: W] = d;
        yaz_temizle[p]     = clr;
    endtask

    task automatic iss(input logic fp, input logic [A-1:0] adr);
        iss_gecerli = 1'b1;
        iss_fp      = fp;
        iss_adr     = adr;
    endtask

    // Advance to the next falling edge (the rising edge in between commits).
    task automatic cyc();
        @(negedge clk);
        idle();
    endtask

    initial begin
        rstn    = 1'b0;
        oku_adr = '0;
        oku_fp  = '0;
        idle();
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Reset state.
        rd(0, 1'b0, 5'd5); rd(1, 1'b1, 5'd5); rd(2, 1'b0, 5'd0);
        #1;
        chk("rst_int_x5", veri_b[31:0], 32'h0);
        chk("rst_fp_f5", veri_b[63:32], 32'hFFFF_FFFF);
        chk("rst_int_x0", veri_b[95:64], 32'h0);
        chk("rst_mesgul", mesgul_b, 3'b000);
        chk("rst_bekleyen", bekleyen_b, 7'd0);

        // x0 is never written and never busy, even with bypass.
        wr(0, 1'b0, 5'd0, 32'h1234, 1'b0); iss(1'b0, 5'd0); rd(0, 1'b0, 5'd0);
        #1;
        chk("x0_byp_read", veri_b[31:0], 32'h0);
        chk("x0_mesgul_same", mesgul_b[0], 1'b0);
        cyc(); #1;
        chk("x0_read", veri_b[31:0], 32'h0);
        chk("x0_read_nb", veri_n[31:0], 32'h0);
        chk("x0_mesgul", mesgul_b[0], 1'b0);
        chk("x0_bekleyen", bekleyen_b, 7'd0);

        // Same-cycle bypass on port1 write.
        wr(1, 1'b0, 5'd3, 32'hDEAD_BEEF, 1'b0); rd(0, 1'b0, 5'd3);
        #1;
        chk("byp_x3_on", veri_b[31:0], 32'hDEAD_BEEF);
        chk("byp_x3_off", veri_n[31:0], 32'h0);
        cyc(); #1;
        chk("x3_after_on", veri_b[31:0], 32'hDEAD_BEEF);
        chk("x3_after_off", veri_n[31:0], 32'hDEAD_BEEF);

        // Two ports writing f7: the higher port wins.
        wr(0, 1'b1, 5'd7, 32'h11, 1'b0); wr(1, 1'b1, 5'd7, 32'h22, 1'b0);
        rd(0, 1'b1, 5'd7); rd(1, 1'b0, 5'd7);
        #1;
        chk("conf_byp_f7", veri_b[31:0], 32'h22);
        cyc(); #1;
        chk("conf_f7", veri_b[31:0], 32'h22);
        chk("conf_f7_nb", veri_n[31:0], 32'h22);
        chk("conf_x7", veri_b[63:32], 32'h0);

        // Scoreboard: issue sets busy next cycle.
        iss(1'b0, 5'd4); rd(0, 1'b0, 5'd4);
        #1;
        chk("sb_x4_before", mesgul_b[0], 1'b0);
        cyc(); #1;
        chk("sb_x4_busy", mesgul_b[0], 1'b1);
        chk("sb_bek_1", bekleyen_b, 7'd1);
        // Issue and clearing write on x4 together: still busy.
        iss(1'b0, 5'd4); wr(0, 1'b0, 5'd4, 32'h55, 1'b1);
        #1;
        chk("sb_setclr_same_b", mesgul_b[0], 1'b1);
        chk("sb_setclr_same_n", mesgul_n[0], 1'b1);
        chk("sb_setclr_data", veri_b[31:0], 32'h55);
        cyc(); #1;
        chk("sb_setclr_busy", mesgul_b[0], 1'b1);
        chk("sb_setclr_bek", bekleyen_b, 7'd1);
        chk("sb_x4_data", veri_b[31:0], 32'h55);
        // Plain clearing write: bypass drops busy in the same cycle.
        wr(1, 1'b0, 5'd4, 32'h66, 1'b1);
        #1;
        chk("sb_clr_mask_b", mesgul_b[0], 1'b0);
        chk("sb_clr_mask_n", mesgul_n[0], 1'b1);
        cyc(); #1;
        chk("sb_clr_busy", mesgul_b[0], 1'b0);
        chk("sb_clr_bek", bekleyen_b, 7'd0);
        // Clear conflict: port0 clears x8, port1 writes x8 without clear.
        iss(1'b0, 5'd8);
        cyc(); rd(1, 1'b0, 5'd8); #1;
        chk("sb_x8_busy", mesgul_b[1], 1'b1);
        wr(0, 1'b0, 5'd8, 32'h1, 1'b1); wr(1, 1'b0, 5'd8, 32'h2, 1'b0);
        #1;
        chk("sb_x8_conf_data", veri_b[63:32], 32'h2);
        chk("sb_x8_conf_mask", mesgul_b[1], 1'b1);
        cyc(); #1;
        chk("sb_x8_still", mesgul_b[1], 1'b1);
        chk("sb_x8_bek", bekleyen_b, 7'd1);
        chk("sb_x8_val", veri_n[63:32], 32'h2);
        wr(1, 1'b0, 5'd8, 32'h3, 1'b1);
        cyc(); #1;
        chk("sb_x8_freed", bekleyen_b, 7'd0);

        // Flush with a concurrent issue.
        iss(1'b0, 5'd1); cyc();
        iss(1'b0, 5'd2); cyc();
        iss(1'b1, 5'd9); cyc();
        rd(0, 1'b0, 5'd1); rd(2, 1'b1, 5'd9); #1;
        chk("fl_bek_3", bekleyen_b, 7'd3);
        chk("fl_f9_busy", mesgul_b[2], 1'b1);
        chk("fl_x1_busy", mesgul_b[0], 1'b1);
        temizle = 1'b1; iss(1'b0, 5'd6);
        cyc(); rd(1, 1'b0, 5'd6); #1;
        chk("fl_bek_0", bekleyen_b, 7'd0);
        chk("fl_bek_0_nb", bekleyen_n, 7'd0);
        chk("fl_mesgul", mesgul_b, 3'b000);

        // Reset in the middle of activity.
        iss(1'b0, 5'd10); wr(0, 1'b0, 5'd11, 32'hAB, 1'b0);
        cyc(); rd(0, 1'b0, 5'd11); rd(1, 1'b1, 5'd7); #1;
        chk("mr_x11", veri_b[31:0], 32'hAB);
        chk("mr_bek_1", bekleyen_b, 7'd1);
        rstn = 1'b0;
        #1;
        chk("mr_x11_rst", veri_b[31:0], 32'h0);
        chk("mr_f7_rst", veri_b[63:32], 32'hFFFF_FFFF);
        chk("mr_bek_rst", bekleyen_b, 7'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("mr_after", veri_n[31:0], 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
